maq_regressiva: RTL and testbench

//  Countdown timer for the digital clock: the borrowing counterpart of the up-counting

---
 rtl/maq_regressiva.sv | 196 +++++++++++++++++++
 tb/tb_maq_regressiva.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maq_regressiva.sv
// -----------------------------------------------------------------------------
// maq_regressiva -- BCD MM:SS countdown timer for the digital clock.
//
// Holds a minutes:seconds value as four BCD digits. It counts down by one second
// on each maqr_enable tick while running. When the count reaches 00:00 it pulses
// maqr_fim for one cycle. It then holds maqr_alarme high for ALARME_TICKS enable
// ticks, or until the alarm is acknowledged with start, cancela or carrega.
//
// Ports
//   maqr_clock        in   system clock, rising edge
//   maqr_reset        in   synchronous active-high reset
//   maqr_enable       in   1-cycle 1 Hz tick shared with the clock counters
//   maqr_carrega      in   load maqr_ld_* (saturated per digit), ignored in RUN
//   maqr_ld_seg_uni   in   load value, seconds units   [3:0]
//   maqr_ld_seg_dez   in   load value, seconds tens    [2:0]
//   maqr_ld_min_uni   in   load value, minutes units   [3:0]
//   maqr_ld_min_dez   in   load value, minutes tens    [2:0]
//   maqr_start        in   start / pause / resume / acknowledge alarm
//   maqr_cancela      in   abort: back to IDLE at 00:00
//   maqr_seg_uni      out  seconds units              [3:0]
//   maqr_seg_dez      out  seconds tens               [2:0]
//   maqr_min_uni      out  minutes units              [3:0]
//   maqr_min_dez      out  minutes tens               [2:0]
//   maqr_estado       out  00 IDLE, 01 RUN, 10 PAUSE, 11 FIM
//   maqr_fim          out  1-cycle pulse on the edge that writes 00:00
//   maqr_alarme       out  alarm level while in FIM
// -----------------------------------------------------------------------------
module maq_regressiva #(
  parameter int SEG_DEZ_MAX  = 5,
  parameter int SEG_UNI_MAX  = 9,
  parameter int MIN_DEZ_MAX  = 5,
  parameter int MIN_UNI_MAX  = 9,
  parameter int ALARME_TICKS = 10
) (
  input  logic       maqr_clock,
  input  logic       maqr_reset,
  input  logic       maqr_enable,
  input  logic       maqr_carrega,
  input  logic [3:0] maqr_ld_seg_uni,
  input  logic [2:0] maqr_ld_seg_dez,
  input  logic [3:0] maqr_ld_min_uni,
  input  logic [2:0] maqr_ld_min_dez,
  input  logic       maqr_start,
  input  logic       maqr_cancela,
  output logic [3:0] maqr_seg_uni,
  output logic [2:0] maqr_seg_dez,
  output logic [3:0] maqr_min_uni,
  output logic [2:0] maqr_min_dez,
  output logic [1:0] maqr_estado,
  output logic       maqr_fim,
  output logic       maqr_alarme
);

  localparam int CNT_W = $clog2(ALARME_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    FIM   = 2'b11
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [3:0]       seg_uni_q, seg_uni_d;
  logic [2:0]       seg_dez_q, seg_dez_d;
  logic [3:0]       min_uni_q, min_uni_d;
  logic [2:0]       min_dez_q, min_dez_d;
  logic             fim_q, fim_d;
  logic             alarme_q, alarme_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             count_zero;

  function automatic logic [3:0] sat4(input logic [3:0] v, input int max);
    return (int'(v) > max) ? 4'(max) : v;
  endfunction

  function automatic logic [2:0] sat3(input logic [2:0] v, input int max);
    return (int'(v) > max) ? 3'(max) : v;
  endfunction

  assign count_zero = (seg_uni_q == '0) && (seg_dez_q == '0) &&
                      (min_uni_q == '0) && (min_dez_q == '0);

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    estado_d  = estado_q;
    seg_uni_d = seg_uni_q;
    seg_dez_d = seg_dez_q;
    min_uni_d = min_uni_q;
    min_dez_d = min_dez_q;
    fim_d     = 1'b0;
    alarme_d  = alarme_q;
    tick_d    = tick_q;

    if (maqr_cancela) begin
      estado_d  = IDLE;
      seg_uni_d = '0;
      seg_dez_d = '0;
      min_uni_d = '0;
      min_dez_d = '0;
      alarme_d  = 1'b0;
      tick_d    = '0;
    end else if (maqr_carrega && estado_q != RUN) begin
      estado_d  = IDLE;
      seg_uni_d = sat4(maqr_ld_seg_uni, SEG_UNI_MAX);
      seg_dez_d = sat3(maqr_ld_seg_dez, SEG_DEZ_MAX);
      min_uni_d = sat4(maqr_ld_min_uni, MIN_UNI_MAX);
      min_dez_d = sat3(maqr_ld_min_dez, MIN_DEZ_MAX);
      alarme_d  = 1'b0;
      tick_d    = '0;
    end else if (maqr_start) begin
      // A load while running is ignored, so start in the same cycle still acts.
      unique case (estado_q)
        IDLE:    if (!count_zero) estado_d = RUN;
        RUN:     estado_d = PAUSE;
        PAUSE:   estado_d = RUN;
        FIM: begin
          estado_d = IDLE;
          alarme_d = 1'b0;
          tick_d   = '0;
        end
        default: estado_d = IDLE;
      endcase
    end else if (maqr_enable) begin
      if (estado_q == RUN && !count_zero) begin
        // Borrow chain: each digit that is already 0 reloads its MAX and
        // borrows from the next digit up.
        if (seg_uni_q != '0) begin
          seg_uni_d = seg_uni_q - 4'd1;
        end else begin
          seg_uni_d = 4'(SEG_UNI_MAX);
          if (seg_dez_q != '0) begin
            seg_dez_d = seg_dez_q - 3'd1;
          end else begin
            seg_dez_d = 3'(SEG_DEZ_MAX);
            if (min_uni_q != '0) begin
              min_uni_d = min_uni_q - 4'd1;
            end else begin
              min_uni_d = 4'(MIN_UNI_MAX);
              min_dez_d = min_dez_q - 3'd1;
            end
          end
        end
        if (seg_uni_d == '0 && seg_dez_d == '0 &&
            min_uni_d == '0 && min_dez_d == '0) begin
          estado_d = FIM;
          fim_d    = 1'b1;
          alarme_d = 1'b1;
          tick_d   = '0;
        end
      end else if (estado_q == FIM) begin
        if (tick_q == CNT_W'(ALARME_TICKS - 1)) begin
          estado_d = IDLE;
          alarme_d = 1'b0;
          tick_d   = '0;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge maqr_clock) begin
    if (maqr_reset) begin
      estado_q  <= IDLE;
      seg_uni_q <= '0;
      seg_dez_q <= '0;
      min_uni_q <= '0;
      min_dez_q <= '0;
      fim_q     <= 1'b0;
      alarme_q  <= 1'b0;
      tick_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      seg_uni_q <= seg_uni_d;
      seg_dez_q <= seg_dez_d;
      min_uni_q <= min_uni_d;
      min_dez_q <= min_dez_d;
      fim_q     <= fim_d;
      alarme_q  <= alarme_d;
      tick_q    <= tick_d;
    end
  end

  assign maqr_seg_uni = seg_uni_q;
  assign maqr_seg_dez = seg_dez_q;
  assign maqr_min_uni = min_uni_q;
  assign maqr_min_dez = min_dez_q;
  assign maqr_estado  = estado_q;
  assign maqr_fim     = fim_q;
  assign maqr_alarme  = alarme_q;

endmodule

// File: tb/tb_maq_regressiva.sv
// -----------------------------------------------------------------------------
// tb_maq_regressiva -- self-checking bench for maq_regressiva.
// A directed vector table, hand sequences for the long countdown and the alarm
// window, then random stimulus. Every cycle is compared with a reference model
// that keeps the count as a plain number of seconds.
// -----------------------------------------------------------------------------
module tb_maq_regressiva;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_FIM = 3;
  localparam int ALARME_TICKS = 10;

  logic       clk = 1'b0;
  logic       rst, en, ld, st, cn;
  logic [3:0] lsu, lmu;
  logic [2:0] lsd, lmd;
  logic [3:0] su, mu;
  logic [2:0] sd, md;
  logic [1:0] est;
  logic       fim, alm;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_secs, m_st, m_ticks;
  bit m_fim, m_alm;

  typedef struct {
    string      name;
    logic       rst, en, ld, st, cn;
    logic [2:0] lmd;
    logic [3:0] lmu;
    logic [2:0] lsd;
    logic [3:0] lsu;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  maq_regressiva dut (
    .maqr_clock      (clk),
    .maqr_reset      (rst),
    .maqr_enable     (en),
    .maqr_carrega    (ld),
    .maqr_ld_seg_uni (lsu),
    .maqr_ld_seg_dez (lsd),
    .maqr_ld_min_uni (lmu),
    .maqr_ld_min_dez (lmd),
    .maqr_start      (st),
    .maqr_cancela    (cn),
    .maqr_seg_uni    (su),
    .maqr_seg_dez    (sd),
    .maqr_min_uni    (mu),
    .maqr_min_dez    (md),
    .maqr_estado     (est),
    .maqr_fim        (fim),
    .maqr_alarme     (alm)
  );

  function automatic logic [17:0] pk(int d_md, int d_mu, int d_sd, int d_su,
                                     int d_st, int d_f, int d_a);
    return {3'(d_md), 4'(d_mu), 3'(d_sd), 4'(d_su), 2'(d_st), 1'(d_f), 1'(d_a)};
  endfunction

  function automatic string fmt(logic [17:0] v);
    return $sformatf("%0d%0d:%0d%0d est=%0d fim=%0d alm=%0d",
                     v[17:15], v[14:11], v[10:8], v[7:4], v[3:2], v[1], v[0]);
  endfunction

  function automatic logic [17:0] dut_vec();
    return {md, mu, sd, su, est, fim, alm};
  endfunction

  function automatic logic [17:0] model_vec();
    return pk(m_secs / 600, (m_secs / 60) % 10, (m_secs % 60) / 10, m_secs % 10,
              m_st, int'(m_fim), int'(m_alm));
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
    end
  endtask

  // Behavioural reference: count held as total seconds, commands by priority.
  task automatic model_step(input int r, input int e, input int l, input int s, input int c,
                            input int vmd, input int vmu, input int vsd, input int vsu);
    m_fim = 1'b0;
    if (r != 0) begin
      m_secs = 0; m_st = ST_IDLE; m_alm = 0; m_ticks = 0;
    end else if (c != 0) begin
      m_secs = 0; m_st = ST_IDLE; m_alm = 0; m_ticks = 0;
    end else if (l != 0 && m_st != ST_RUN) begin
      m_secs = min_i(vmd, 5) * 600 + min_i(vmu, 9) * 60 + min_i(vsd, 5) * 10 + min_i(vsu, 9);
      m_st = ST_IDLE; m_alm = 0; m_ticks = 0;
    end else if (s != 0) begin
      case (m_st)
        ST_IDLE:  if (m_secs != 0) m_st = ST_RUN;
        ST_RUN:   m_st = ST_PAUSE;
        ST_PAUSE: m_st = ST_RUN;
        default:  begin m_st = ST_IDLE; m_alm = 0; m_ticks = 0; end
      endcase
    end else if (e != 0) begin
      if (m_st == ST_RUN && m_secs > 0) begin
        m_secs--;
        if (m_secs == 0) begin
          m_st = ST_FIM; m_fim = 1; m_alm = 1; m_ticks = 0;
        end
      end else if (m_st == ST_FIM) begin
        m_ticks++;
        if (m_ticks == ALARME_TICKS) begin
          m_st = ST_IDLE; m_alm = 0; m_ticks = 0;
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, sample 1 time unit later.
  task automatic drive(input string name, input logic r, input logic e, input logic l,
                       input logic s, input logic c, input logic [2:0] vmd,
                       input logic [3:0] vmu, input logic [2:0] vsd, input logic [3:0] vsu);
    rst = r; en = e; ld = l; st = s; cn = c;
    lmd = vmd; lmu = vmu; lsd = vsd; lsu = vsu;
    @(posedge clk);
    #1;
    model_step(int'(r), int'(e), int'(l), int'(s), int'(c),
               int'(vmd), int'(vmu), int'(vsd), int'(vsu));
    check({name, "/model"}, dut_vec(), model_vec());
  endtask

  task automatic nop(input string name);
    drive(name, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input string name);
    drive(name, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic add(input string name, input logic r, input logic e, input logic l,
                     input logic s, input logic c, input int vmd, input int vmu,
                     input int vsd, input int vsu, input int xmd, input int xmu,
                     input int xsd, input int xsu, input int xst, input int xf, input int xa);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.ld = l; v.st = s; v.cn = c;
    v.lmd = 3'(vmd); v.lmu = 4'(vmu); v.lsd = 3'(vsd); v.lsu = 4'(vsu);
    v.exp = pk(xmd, xmu, xsd, xsu, xst, xf, xa);
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 0; ld = 0; st = 0; cn = 0;
    lmd = 0; lmu = 0; lsd = 0; lsu = 0;
    m_secs = 0; m_st = ST_IDLE; m_ticks = 0; m_fim = 0; m_alm = 0;

    //   name            r e l s c  ld md mu sd su   exp md mu sd su st f a
    add("reset",         1,0,0,0,0, 0,0,0,0,   0,0,0,0, ST_IDLE,0,0);
    add("ld_zero",       0,0,1,0,0, 0,0,0,0,   0,0,0,0, ST_IDLE,0,0);
    add("start_zero",    0,0,0,1,0, 0,0,0,0,   0,0,0,0, ST_IDLE,0,0);
    add("ld_sat_sec",    0,0,1,0,0, 0,0,7,12,  0,0,5,9, ST_IDLE,0,0);
    add("ld_sat_min",    0,0,1,0,0, 7,15,4,5,  5,9,4,5, ST_IDLE,0,0);
    add("ld_0045",       0,0,1,0,0, 0,0,4,5,   0,0,4,5, ST_IDLE,0,0);
    add("start_en_idle", 0,1,0,1,0, 0,0,0,0,   0,0,4,5, ST_RUN,0,0);
    add("tick_run",      0,1,0,0,0, 0,0,0,0,   0,0,4,4, ST_RUN,0,0);
    add("start_en_run",  0,1,0,1,0, 0,0,0,0,   0,0,4,4, ST_PAUSE,0,0);
    add("tick_pause",    0,1,0,0,0, 0,0,0,0,   0,0,4,4, ST_PAUSE,0,0);
    add("resume",        0,0,0,1,0, 0,0,0,0,   0,0,4,4, ST_RUN,0,0);
    add("tick_resume",   0,1,0,0,0, 0,0,0,0,   0,0,4,3, ST_RUN,0,0);
    add("ld_in_run",     0,0,1,0,0, 0,1,3,0,   0,0,4,3, ST_RUN,0,0);
    add("ld_cancel",     0,0,1,0,1, 0,1,3,0,   0,0,0,0, ST_IDLE,0,0);
    add("ld_0100",       0,0,1,0,0, 0,1,0,0,   0,1,0,0, ST_IDLE,0,0);
    add("start_0100",    0,0,0,1,0, 0,0,0,0,   0,1,0,0, ST_RUN,0,0);
    add("borrow_min",    0,1,0,0,0, 0,0,0,0,   0,0,5,9, ST_RUN,0,0);
    add("cancel_run",    0,0,0,0,1, 0,0,0,0,   0,0,0,0, ST_IDLE,0,0);
    add("ld_0001",       0,0,1,0,0, 0,0,0,1,   0,0,0,1, ST_IDLE,0,0);
    add("start_0001",    0,0,0,1,0, 0,0,0,0,   0,0,0,1, ST_RUN,0,0);
    add("reach_zero",    0,1,0,0,0, 0,0,0,0,   0,0,0,0, ST_FIM,1,1);
    add("fim_hold",      0,0,0,0,0, 0,0,0,0,   0,0,0,0, ST_FIM,0,1);
    add("ack_alarm",     0,0,0,1,0, 0,0,0,0,   0,0,0,0, ST_IDLE,0,0);
    add("ld_0001_b",     0,0,1,0,0, 0,0,0,1,   0,0,0,1, ST_IDLE,0,0);
    add("start_b",       0,0,0,1,0, 0,0,0,0,   0,0,0,1, ST_RUN,0,0);
    add("reach_zero_b",  0,1,0,0,0, 0,0,0,0,   0,0,0,0, ST_FIM,1,1);
    add("alarm_tick",    0,1,0,0,0, 0,0,0,0,   0,0,0,0, ST_FIM,0,1);
    add("reset_fim",     1,0,0,0,0, 0,0,0,0,   0,0,0,0, ST_IDLE,0,0);
    add("ld_0010",       0,0,1,0,0, 0,0,1,0,   0,0,1,0, ST_IDLE,0,0);
    add("start_0010",    0,0,0,1,0, 0,0,0,0,   0,0,1,0, ST_RUN,0,0);
    add("pause_0010",    0,0,0,1,0, 0,0,0,0,   0,0,1,0, ST_PAUSE,0,0);
    add("ld_in_pause",   0,0,1,0,0, 0,2,0,0,   0,2,0,0, ST_IDLE,0,0);
    add("start_0200",    0,0,0,1,0, 0,0,0,0,   0,2,0,0, ST_RUN,0,0);
    add("reset_run",     1,1,0,0,0, 0,0,0,0,   0,0,0,0, ST_IDLE,0,0);
    add("ld_0001_c",     0,0,1,0,0, 0,0,0,1,   0,0,0,1, ST_IDLE,0,0);
    add("start_c",       0,0,0,1,0, 0,0,0,0,   0,0,0,1, ST_RUN,0,0);
    add("reach_zero_c",  0,1,0,0,0, 0,0,0,0,   0,0,0,0, ST_FIM,1,1);
    add("ld_in_fim",     0,0,1,0,0, 0,3,0,0,   0,3,0,0, ST_IDLE,0,0);

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].st, vecs[i].cn,
            vecs[i].lmd, vecs[i].lmu, vecs[i].lsd, vecs[i].lsu);
      check(vecs[i].name, dut_vec(), vecs[i].exp);
    end

    // 01:30 countdown over 90 ticks, spaced like a real 1 Hz enable.
    drive("r90", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("ld_0130", 0, 0, 1, 0, 0, 0, 1, 3, 0);
    drive("start_0130", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 90; i++) begin
      tick("cd90");
      if (i == 1)  check("cd90_first", dut_vec(), pk(0, 1, 2, 9, ST_RUN, 0, 0));
      if (i == 31) check("cd90_31st", dut_vec(), pk(0, 0, 5, 9, ST_RUN, 0, 0));
      if (i == 90) check("cd90_end", dut_vec(), pk(0, 0, 0, 0, ST_FIM, 1, 1));
      nop("cd90_gap");
    end
    check("cd90_fim_drop", dut_vec(), pk(0, 0, 0, 0, ST_FIM, 0, 1));

    // Alarm window: 00:02, then the alarm lasts exactly ALARME_TICKS ticks.
    drive("ld_0002", 0, 0, 1, 0, 0, 0, 0, 0, 2);
    drive("start_0002", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick("t1_0002");
    nop("gap_0002");
    tick("t2_0002");
    check("alarm_enter", dut_vec(), pk(0, 0, 0, 0, ST_FIM, 1, 1));
    nop("alarm_gap0");
    check("alarm_pulse_1cyc", dut_vec(), pk(0, 0, 0, 0, ST_FIM, 0, 1));
    for (int k = 1; k <= ALARME_TICKS; k++) begin
      tick("alarm_tick");
      if (k < ALARME_TICKS) check("alarm_held", dut_vec(), pk(0, 0, 0, 0, ST_FIM, 0, 1));
      else                  check("alarm_done", dut_vec(), pk(0, 0, 0, 0, ST_IDLE, 0, 0));
      nop("alarm_gap");
    end

    // Random stimulus against the model; loads lean toward short counts so
    // the FIM and alarm paths are visited often.
    drive("rand_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      logic r, e, l, s, c;
      logic [2:0] vmd, vsd;
      logic [3:0] vmu, vsu;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 11) == 0);
      e = ($urandom_range(0, 2) == 0);
      vmd = 3'($urandom_range(0, 7));
      vmu = 4'($urandom_range(0, 15));
      vsd = 3'($urandom_range(0, 7));
      vsu = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        vmd = 0;
        vmu = 0;
        vsd = 3'($urandom_range(0, 1));
      end
      drive("rand", r, e, l, s, c, vmd, vmu, vsd, vsu);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
